// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Writeback arbiter ahead of the 16x16 register file. Merges ALU
//            results and buffered load returns onto the one write port.
//            ALU wins by default, but it is held off after STARVE_LIMIT
//            consecutive wins while loads are waiting. A 16-entry
//            pending-load scoreboard reports the busy state of rs1/rs2.
//            Optional macro WB_PERF_EN adds the saturating stall counters
//            ld_stall_cnt and alu_stall_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int LD_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [3:0]  alu_rd,
    input  logic [15:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [3:0]  ld_rd,
    input  logic [15:0] ld_data,
    input  logic        ld_issue,
    input  logic [3:0]  ld_issue_rd,
    input  logic [3:0]  rs1,
    input  logic [3:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
`ifdef WB_PERF_EN
    output logic [15:0] ld_stall_cnt,
    output logic [15:0] alu_stall_cnt,
`endif
    output logic        wb_we,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_data
);

    localparam int c_PTR_W = $clog2(LD_FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(LD_FIFO_DEPTH);
    localparam logic [c_STV_W-1:0] c_LIMIT = c_STV_W'(STARVE_LIMIT);

    // Which source drives the write port this cycle
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_POP  = 2'd2,
        SEL_BYP  = 2'd3
    } sel_e;

    logic [19:0]        mem_q [LD_FIFO_DEPTH];
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [c_STV_W-1:0] starve_q, starve_d;
    logic [15:0]        busy_q, busy_d;
    logic               wb_we_q, wb_we_d;
    logic [3:0]         wb_rd_q, wb_rd_d;
    logic [15:0]        wb_data_q, wb_data_d;

    sel_e               sel;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic [3:0]         head_rd;
    logic [15:0]        head_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == c_DEPTH);
    assign head_rd    = mem_q[rd_ptr_q][19:16];
    assign head_data  = mem_q[rd_ptr_q][15:0];

    assign ld_ready   = !fifo_full;
    assign rs1_busy   = (rs1 != 4'd0) && busy_q[rs1];
    assign rs2_busy   = (rs2 != 4'd0) && busy_q[rs2];
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;

    // Source selection, starvation tracking and writeback next-state
    always_comb begin
        sel       = SEL_NONE;
        alu_ready = 1'b1;
        starve_d  = '0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        wb_we_d   = 1'b0;
        if (!fifo_empty && (starve_q == c_LIMIT)) begin
            sel       = SEL_POP;
            alu_ready = 1'b0;
        end else if (alu_valid) begin
            sel      = SEL_ALU;
            starve_d = fifo_empty ? '0 : starve_q + c_STV_W'(1);
        end else if (!fifo_empty) begin
            sel = SEL_POP;
        end else if (ld_valid) begin
            sel = SEL_BYP;
        end

        case (sel)
            SEL_ALU: begin
                wb_rd_d   = alu_rd;
                wb_data_d = alu_data;
                wb_we_d   = (alu_rd != 4'd0);
            end
            SEL_POP: begin
                wb_rd_d   = head_rd;
                wb_data_d = head_data;
                wb_we_d   = (head_rd != 4'd0);
            end
            SEL_BYP: begin
                wb_rd_d   = ld_rd;
                wb_data_d = ld_data;
                wb_we_d   = (ld_rd != 4'd0);
            end
            default: ;
        endcase
    end

    // FIFO pointer and occupancy next-state; a bypassed load is never pushed
    always_comb begin
        pop      = (sel == SEL_POP);
        push     = ld_valid && !fifo_full && (sel != SEL_BYP);
        rd_ptr_d = pop  ? rd_ptr_q + c_PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + c_PTR_W'(1) : wr_ptr_q;
        count_d  = count_q + (push ? c_CNT_W'(1) : '0) - (pop ? c_CNT_W'(1) : '0);
    end

    // Scoreboard: clear on load selection first, so a same-register issue wins
    always_comb begin
        busy_d = busy_q;
        if (sel == SEL_POP) begin
            busy_d[head_rd] = 1'b0;
        end else if (sel == SEL_BYP) begin
            busy_d[ld_rd] = 1'b0;
        end
        if (ld_issue && (ld_issue_rd != 4'd0)) begin
            busy_d[ld_issue_rd] = 1'b1;
        end
    end

    // Control state and registered writeback outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            busy_q    <= '0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= 4'd0;
            wb_data_q <= 16'd0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            busy_q    <= busy_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    // FIFO storage; contents are don't-care while the occupancy says empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ld_rd, ld_data};
        end
    end

`ifdef WB_PERF_EN
    logic [15:0] ld_stall_q, ld_stall_d;
    logic [15:0] alu_stall_q, alu_stall_d;

    // Saturating stall counters
    always_comb begin
        ld_stall_d  = ld_stall_q;
        alu_stall_d = alu_stall_q;
        if (ld_valid && !ld_ready && (ld_stall_q != 16'hFFFF)) begin
            ld_stall_d = ld_stall_q + 16'd1;
        end
        if (alu_valid && !alu_ready && (alu_stall_q != 16'hFFFF)) begin
            alu_stall_d = alu_stall_q + 16'd1;
        end
    end

    // Stall counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_stall_q  <= 16'd0;
            alu_stall_q <= 16'd0;
        end else begin
            ld_stall_q  <= ld_stall_d;
            alu_stall_q <= alu_stall_d;
        end
    end

    assign ld_stall_cnt  = ld_stall_q;
    assign alu_stall_cnt = alu_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Self-checking bench for wb_arbiter. A queue-based reference model
//            predicts each cycle's writeback; a monitor process compares the
//            registered outputs one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int c_DEPTH = 4;
    localparam int c_LIMIT = 3;

    typedef struct {
        logic [3:0]  rd;
        logic [15:0] data;
    } ent_t;

    typedef struct {
        logic        we;
        logic [3:0]  rd;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0, ld_valid = 1'b0, ld_issue = 1'b0;
    logic [3:0]  alu_rd = '0, ld_rd = '0, ld_issue_rd = '0, rs1 = '0, rs2 = '0;
    logic [15:0] alu_data = '0, ld_data = '0;
    logic        alu_ready, ld_ready, rs1_busy, rs2_busy, wb_we;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
`ifdef WB_PERF_EN
    logic [15:0] ld_stall_cnt, alu_stall_cnt;
    int          m_ld_stall, m_alu_stall;
`endif

    int   tests = 0;
    int   errors = 0;
    ent_t m_fifo[$];
    exp_t exp_q[$];
    int   m_starve;
    bit   m_busy [16];
    bit   m_acc;

    wb_arbiter #(.LD_FIFO_DEPTH(c_DEPTH), .STARVE_LIMIT(c_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef WB_PERF_EN
        .ld_stall_cnt(ld_stall_cnt), .alu_stall_cnt(alu_stall_cnt),
`endif
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_starve = 0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
`ifdef WB_PERF_EN
        m_ld_stall  = 0;
        m_alu_stall = 0;
`endif
    endtask

    // One clock cycle: drive, check combinational outputs, predict writeback
    task automatic step(input bit av, input logic [3:0] ar, input logic [15:0] ad,
                        input bit lv, input logic [3:0] lr, input logic [15:0] ldd,
                        input bit iv, input logic [3:0] ir,
                        input logic [3:0] r1, input logic [3:0] r2);
        bit   empty, full, exp_alu_rdy, sel, byp;
        ent_t it;
        exp_t e;
        @(posedge clk);
        #1;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid = lv; ld_rd = lr; ld_data = ldd;
        ld_issue = iv; ld_issue_rd = ir; rs1 = r1; rs2 = r2;
        #4;
        empty = (m_fifo.size() == 0);
        full  = (m_fifo.size() == c_DEPTH);
        exp_alu_rdy = !(!empty && m_starve == c_LIMIT);
        chk("ld_ready", 32'(ld_ready), 32'(!full));
        chk("alu_ready", 32'(alu_ready), 32'(exp_alu_rdy));
        chk("rs1_busy", 32'(rs1_busy), 32'(r1 != 0 && m_busy[r1]));
        chk("rs2_busy", 32'(rs2_busy), 32'(r2 != 0 && m_busy[r2]));
`ifdef WB_PERF_EN
        if (lv && full && m_ld_stall < 65535) m_ld_stall++;
        if (av && !exp_alu_rdy && m_alu_stall < 65535) m_alu_stall++;
`endif
        sel = 1'b1;
        byp = 1'b0;
        it.rd = '0;
        it.data = '0;
        if (!empty && m_starve == c_LIMIT) begin
            it = m_fifo.pop_front();
            m_busy[it.rd] = 1'b0;
            m_starve = 0;
        end else if (av) begin
            it.rd = ar;
            it.data = ad;
            m_starve = empty ? 0 : m_starve + 1;
        end else if (!empty) begin
            it = m_fifo.pop_front();
            m_busy[it.rd] = 1'b0;
            m_starve = 0;
        end else if (lv) begin
            it.rd = lr;
            it.data = ldd;
            m_busy[lr] = 1'b0;
            byp = 1'b1;
            m_starve = 0;
        end else begin
            sel = 1'b0;
        end
        m_acc = lv && !full;
        if (m_acc && !byp) begin
            it.rd = it.rd; // keep selected item intact
            m_fifo.push_back('{rd: lr, data: ldd});
        end
        if (iv && ir != 0) m_busy[ir] = 1'b1;
        e.we = sel && (it.rd != 0);
        e.rd = it.rd;
        e.data = it.data;
        exp_q.push_back(e);
    endtask

    // Monitor: compares registered writeback against the predicted entry
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wb_we", 32'(wb_we), 32'(e.we));
                if (e.we) begin
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_data", 32'(wb_data), 32'(e.data));
                end
            end
        end
    end

    task automatic idle(input logic [3:0] r1);
        step(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    initial begin
        model_reset();
        #3;
        chk("rst_wb_we", 32'(wb_we), 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_wb_data", 32'(wb_data), 0);
        chk("rst_alu_ready", 32'(alu_ready), 1);
        chk("rst_ld_ready", 32'(ld_ready), 1);
        #14 rst_n = 1'b1;

        // ALU writes, including silent rd=0
        step(1, 3, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 16'h5555, 0, 0, 0, 0, 0, 0, 0);
        idle(0);

        // Load scoreboard and bypass
        step(0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
        step(0, 0, 0, 1, 5, 16'hBEEF, 0, 0, 5, 0);
        idle(5);

        // ALU held high with loads rd=1..5 offered until accepted
        for (int n = 1; n <= 5; n++) begin
            for (int t = 0; t < 20; t++) begin
                step(1, 4'(8 + t % 7), 16'(16'hA000 + t), 1, 4'(n), 16'(16'hC000 + n), 0, 0, 4'(n), 0);
                if (m_acc) break;
            end
        end
        for (int t = 0; t < 12; t++) idle(0);

        // Same-cycle issue and pop of rd=7: the issue wins
        step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        step(1, 1, 16'h1111, 1, 7, 16'h7777, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        idle(7);

        // Randomized traffic
        for (int t = 0; t < 1500; t++) begin
            step(($urandom_range(0, 99) < 70), 4'($urandom), 16'($urandom),
                 ($urandom_range(0, 99) < 60), 4'($urandom), 16'($urandom),
                 ($urandom_range(0, 99) < 40), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        // Reset mid-stream with buffered loads and busy bits 4..7
        for (int t = 0; t < 4; t++) begin
            step(1, 2, 16'h2222, 1, 4'(4 + t), 16'(16'hD000 + t), 1, 4'(4 + t), 0, 0);
        end
        @(posedge clk);
        #3;
        alu_valid = 0; ld_valid = 0; ld_issue = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_wb_we", 32'(wb_we), 0);
        chk("mid_rst_wb_rd", 32'(wb_rd), 0);
        chk("mid_rst_ld_ready", 32'(ld_ready), 1);
        chk("mid_rst_alu_ready", 32'(alu_ready), 1);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        for (int r = 4; r < 8; r++) idle(4'(r));
        step(1, 9, 16'h9999, 0, 0, 0, 0, 0, 0, 0);
        for (int t = 0; t < 300; t++) begin
            step(($urandom_range(0, 99) < 80), 4'($urandom), 16'($urandom),
                 ($urandom_range(0, 99) < 70), 4'($urandom), 16'($urandom),
                 ($urandom_range(0, 99) < 40), 4'($urandom), 4'($urandom), 4'($urandom));
        end
        idle(0);
        @(posedge clk);
        #3;
`ifdef WB_PERF_EN
        chk("ld_stall_cnt", 32'(ld_stall_cnt), 32'(m_ld_stall));
        chk("alu_stall_cnt", 32'(alu_stall_cnt), 32'(m_alu_stall));
`endif
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
